writeback_tracker: RTL and testbench

- Producer side of the operand-forwarding interface.
- Carries destination-register metadata (rd, reg_write, mem_read) down the ID/EX -> EX/MEM -> MEM/WB pipeline registers and drives the id_ex_rs*, ex_mem_*, mem_wb_* signals the forwarding unit consumes.
- Also generates load-use stalls, branch flush bubbles and multi-cycle data-memory freezes.
- Sits beside the datapath pipeline registers in the 5-stage core.

---
 rtl/writeback_tracker_pkg.sv | 22 ++
 rtl/writeback_tracker_if.sv | 35 +++
 rtl/writeback_tracker_hazard_stall_ctrl.sv | 58 +++++
 rtl/writeback_tracker.sv | 140 ++++++++++++++
 tb/tb_writeback_tracker.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_tracker_pkg.sv
// rtl/writeback_tracker_pkg.sv - shared types for the writeback tracker
package writeback_tracker_pkg;

  localparam int DEF_REG_AW = 5;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic                  valid;
    logic [DEF_REG_AW-1:0] rd;
    logic [DEF_REG_AW-1:0] rs1;
    logic [DEF_REG_AW-1:0] rs2;
    logic                  reg_write;
    logic                  mem_read;
  } stage_meta_t;

  localparam stage_meta_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/writeback_tracker_if.sv
// rtl/writeback_tracker_if.sv - ID-stage metadata in, forwarding-unit metadata out
interface writeback_tracker_if;
  import writeback_tracker_pkg::*;

  logic                  id_valid;
  logic [DEF_REG_AW-1:0] id_rs1;
  logic [DEF_REG_AW-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [DEF_REG_AW-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;

  logic [DEF_REG_AW-1:0] id_ex_rs1;
  logic [DEF_REG_AW-1:0] id_ex_rs2;
  logic [DEF_REG_AW-1:0] ex_mem_rd;
  logic                  ex_mem_reg_write;
  logic [DEF_REG_AW-1:0] mem_wb_rd;
  logic                  mem_wb_reg_write;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_reg_write, id_mem_read,
    input  id_ex_rs1, id_ex_rs2, ex_mem_rd, ex_mem_reg_write,
           mem_wb_rd, mem_wb_reg_write
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_reg_write, id_mem_read,
    output id_ex_rs1, id_ex_rs2, ex_mem_rd, ex_mem_reg_write,
           mem_wb_rd, mem_wb_reg_write
  );

endinterface

// File: rtl/writeback_tracker_hazard_stall_ctrl.sv
// rtl/writeback_tracker_hazard_stall_ctrl.sv - load-use / freeze / flush priority decode
module hazard_stall_ctrl
  import writeback_tracker_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              idex_valid,
  input  logic              idex_mem_read,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              exmem_valid,
  input  logic              exmem_mem_read,
  input  logic              ex_flush,
  input  logic              mem_ready,
  output logic              freeze,
  output logic              insert_bubble,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_id
);

  logic rs1_hit;
  logic rs2_hit;
  logic load_use;

  assign rs1_hit  = id_uses_rs1 && (id_rs1 == idex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == idex_rd);
  assign load_use = id_valid && idex_valid && idex_mem_read &&
                    (idex_rd != '0) && (rs1_hit || rs2_hit);
  assign freeze   = exmem_valid && exmem_mem_read && !mem_ready;

  // A taken branch squashes the ID instruction, so its load-use hazard is moot.
  always_comb begin
    insert_bubble = 1'b0;
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    bubble_ex     = 1'b0;
    flush_id      = 1'b0;
    if (freeze) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
    end else if (ex_flush) begin
      insert_bubble = 1'b1;
      flush_id      = 1'b1;
    end else if (load_use) begin
      insert_bubble = 1'b1;
      stall_if      = 1'b1;
      stall_id      = 1'b1;
      bubble_ex     = 1'b1;
    end
  end

endmodule

// File: rtl/writeback_tracker.sv
// rtl/writeback_tracker.sv - destination metadata pipeline, stalls and memory-wait FSM
module writeback_tracker
  import writeback_tracker_pkg::*;
#(
  parameter int REG_AW   = DEF_REG_AW,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  writeback_tracker_if.slave    bus,
  input  logic                  ex_flush,
  input  logic                  mem_ready,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic                  flush_id,
  output logic                  mem_wait,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  stage_meta_t id_cap;
  stage_meta_t id_ex;
  stage_meta_t ex_mem;
  stage_meta_t mem_wb;

  wb_state_e         state;
  wb_state_e         state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_nxt;
  logic              timeout_nxt;

  logic freeze;
  logic insert_bubble;
  logic unused_meta;

  hazard_stall_ctrl #(.REG_AW(REG_AW)) u_hazard (
    .id_valid       (bus.id_valid),
    .id_rs1         (bus.id_rs1),
    .id_rs2         (bus.id_rs2),
    .id_uses_rs1    (bus.id_uses_rs1),
    .id_uses_rs2    (bus.id_uses_rs2),
    .idex_valid     (id_ex.valid),
    .idex_mem_read  (id_ex.mem_read),
    .idex_rd        (id_ex.rd),
    .exmem_valid    (ex_mem.valid),
    .exmem_mem_read (ex_mem.mem_read),
    .ex_flush       (ex_flush),
    .mem_ready      (mem_ready),
    .freeze         (freeze),
    .insert_bubble  (insert_bubble),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .bubble_ex      (bubble_ex),
    .flush_id       (flush_id)
  );

  // x0 is tracked like any register but can never be a forwarding source.
  always_comb begin
    id_cap           = STAGE_BUBBLE;
    id_cap.valid     = bus.id_valid;
    id_cap.rd        = bus.id_rd;
    id_cap.rs1       = bus.id_rs1;
    id_cap.rs2       = bus.id_rs2;
    id_cap.reg_write = bus.id_reg_write && (bus.id_rd != '0);
    id_cap.mem_read  = bus.id_mem_read;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex  <= STAGE_BUBBLE;
      ex_mem <= STAGE_BUBBLE;
      mem_wb <= STAGE_BUBBLE;
    end else if (!freeze) begin
      id_ex  <= insert_bubble ? STAGE_BUBBLE : id_cap;
      ex_mem <= id_ex;
      mem_wb <= ex_mem;
    end
  end

  // While in MEM_WAIT the load is parked in EX/MEM, so freeze == !mem_ready.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_nxt  = mem_timeout;
    if (state == ST_RUN) begin
      if (freeze) begin
        state_nxt    = ST_MEM_WAIT;
        wait_cnt_nxt = '0;
      end
    end else begin
      if (mem_ready) begin
        state_nxt = ST_RUN;
      end else begin
        if (wait_cnt != WAIT_LIMIT) begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
        if (wait_cnt_nxt == WAIT_LIMIT) begin
          timeout_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_timeout <= timeout_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall_id && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  assign mem_wait = (state == ST_MEM_WAIT);

  assign bus.id_ex_rs1        = id_ex.rs1;
  assign bus.id_ex_rs2        = id_ex.rs2;
  assign bus.ex_mem_rd        = ex_mem.rd;
  assign bus.ex_mem_reg_write = ex_mem.valid && ex_mem.reg_write;
  assign bus.mem_wb_rd        = mem_wb.rd;
  assign bus.mem_wb_reg_write = mem_wb.valid && mem_wb.reg_write;

  assign unused_meta = ^{mem_wb.rs1, mem_wb.rs2, mem_wb.mem_read};

endmodule

// File: tb/tb_writeback_tracker.sv
// tb/tb_writeback_tracker.sv - randomized and directed bench for writeback_tracker
module tb_writeback_tracker;
  import writeback_tracker_pkg::*;

  localparam int MAX_WAIT = 64;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ex_flush = 1'b0;
  logic             mem_ready = 1'b1;
  logic             stall_if, stall_id, bubble_ex, flush_id, mem_wait, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  writeback_tracker_if bus();

  writeback_tracker #(.REG_AW(DEF_REG_AW), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .ex_flush     (ex_flush),
    .mem_ready    (mem_ready),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .bubble_ex    (bubble_ex),
    .flush_id     (flush_id),
    .mem_wait     (mem_wait),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  // Reference: a three-slot instruction pipe [ID/EX, EX/MEM, MEM/WB].
  typedef struct {
    logic       v;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rw;
    logic       mr;
  } mstage_t;

  mstage_t     mp [3];
  int unsigned m_stalls;
  int unsigned m_wait_run;
  bit          m_wait;
  bit          m_timeout;
  bit          e_freeze, e_lu, e_stall, e_bubble, e_flush;
  int          n_pass = 0;
  int          n_total = 0;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) mp[i] = '{default: '0};
    m_stalls   = 0;
    m_wait_run = 0;
    m_wait     = 0;
    m_timeout  = 0;
  endfunction

  function automatic void model_eval();
    e_freeze = mp[1].v && mp[1].mr && !mem_ready;
    e_lu = bus.id_valid && mp[0].v && mp[0].mr && (mp[0].rd != 0) &&
           ((bus.id_uses_rs1 && bus.id_rs1 == mp[0].rd) ||
            (bus.id_uses_rs2 && bus.id_rs2 == mp[0].rd));
    e_flush  = !e_freeze && ex_flush;
    e_bubble = !e_freeze && !ex_flush && e_lu;
    e_stall  = e_freeze || e_bubble;
  endfunction

  function automatic void model_edge();
    if (e_stall && m_stalls < 65535) m_stalls++;
    if (e_freeze) begin
      if (m_wait) begin
        m_wait_run++;
        if (m_wait_run >= MAX_WAIT) m_timeout = 1;
      end else begin
        m_wait_run = 0;
      end
      m_wait = 1;
    end else begin
      m_wait = 0;
      mp[2] = mp[1];
      mp[1] = mp[0];
      if (ex_flush || e_lu) mp[0] = '{default: '0};
      else mp[0] = '{bus.id_valid, bus.id_rd, bus.id_rs1, bus.id_rs2,
                     bus.id_reg_write && (bus.id_rd != 0), bus.id_mem_read};
    end
  endfunction

  function automatic logic [43:0] dut_vec();
    return {bus.id_ex_rs1, bus.id_ex_rs2, bus.ex_mem_rd, bus.ex_mem_reg_write,
            bus.mem_wb_rd, bus.mem_wb_reg_write, stall_if, stall_id, bubble_ex,
            flush_id, mem_wait, mem_timeout, stall_cycles};
  endfunction

  function automatic logic [43:0] model_vec();
    return {mp[0].rs1, mp[0].rs2, mp[1].rd, mp[1].v & mp[1].rw,
            mp[2].rd, mp[2].v & mp[2].rw, e_stall, e_stall, e_bubble,
            e_flush, m_wait, m_timeout, 16'(m_stalls)};
  endfunction

  task automatic set_id(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic rw, input logic mr);
    bus.id_valid     = v;
    bus.id_rd        = rd;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_uses_rs1  = u1;
    bus.id_uses_rs2  = u2;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    ex_flush  = 0;
    mem_ready = 1;
    rst_n     = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    tick();
  endtask

  task automatic test_reset();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (dut_vec() !== 44'd0) $display("FAIL reset_during: got %h want 0", dut_vec());
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    #1;
    n_total++;
    if (dut_vec() !== 44'd0) $display("FAIL reset_after: got %h want 0", dut_vec());
    else n_pass++;
    tick();
    @(negedge clk);
    model_eval();
    n_total++;
    if (dut_vec() !== model_vec()) $display("FAIL reset_idle: got %h want %h", dut_vec(), model_vec());
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_id(1, 5, 1, 2, 1, 1, 1, 0);
    @(negedge clk);
    model_eval();
    n_total++;
    if (stall_id !== 1'b0) $display("FAIL b2b_first_stall: got %b want 0", stall_id);
    else n_pass++;
    tick();
    set_id(1, 6, 5, 1, 1, 1, 1, 0);
    @(negedge clk);
    model_eval();
    n_total++;
    if (dut_vec() !== model_vec()) $display("FAIL b2b_second: got %h want %h", dut_vec(), model_vec());
    else n_pass++;
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    model_eval();
    n_total++;
    if ({bus.ex_mem_rd, bus.ex_mem_reg_write, bus.id_ex_rs1, stall_id} !== {5'd5, 1'b1, 5'd5, 1'b0})
      $display("FAIL b2b_forward: got rd=%0d rw=%b rs1=%0d stall=%b want 5 1 5 0",
               bus.ex_mem_rd, bus.ex_mem_reg_write, bus.id_ex_rs1, stall_id);
    else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 7, 3, 0, 1, 0, 1, 1);
    tick();
    set_id(1, 8, 7, 2, 1, 1, 1, 0);
    @(negedge clk);
    model_eval();
    n_total++;
    if ({stall_if, stall_id, bubble_ex, flush_id} !== 4'b1110)
      $display("FAIL lu_stall: got %b want 1110", {stall_if, stall_id, bubble_ex, flush_id});
    else n_pass++;
    tick();
    @(negedge clk);
    model_eval();
    n_total++;
    if ({stall_id, bubble_ex, bus.id_ex_rs1, bus.ex_mem_rd, bus.ex_mem_reg_write, stall_cycles} !==
        {1'b0, 1'b0, 5'd0, 5'd7, 1'b1, 16'd1})
      $display("FAIL lu_after: got stall=%b bub=%b rs1=%0d rd=%0d rw=%b cnt=%0d want 0 0 0 7 1 1",
               stall_id, bubble_ex, bus.id_ex_rs1, bus.ex_mem_rd, bus.ex_mem_reg_write, stall_cycles);
    else n_pass++;
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    model_eval();
    n_total++;
    if ({bus.id_ex_rs1, bus.id_ex_rs2, stall_id} !== {5'd7, 5'd2, 1'b0})
      $display("FAIL lu_reissue: got rs1=%0d rs2=%0d stall=%b want 7 2 0",
               bus.id_ex_rs1, bus.id_ex_rs2, stall_id);
    else n_pass++;
    tick();
  endtask

  task automatic test_flush_load_use();
    do_reset();
    set_id(1, 7, 3, 0, 1, 0, 1, 1);
    tick();
    set_id(1, 8, 7, 2, 1, 1, 1, 0);
    ex_flush = 1;
    @(negedge clk);
    model_eval();
    n_total++;
    if ({flush_id, stall_id, stall_if, bubble_ex} !== 4'b1000)
      $display("FAIL flush_lu: got %b want 1000", {flush_id, stall_id, stall_if, bubble_ex});
    else n_pass++;
    tick();
    ex_flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    model_eval();
    n_total++;
    if ({bus.id_ex_rs1, bus.id_ex_rs2, bus.ex_mem_rd, stall_cycles} !== {5'd0, 5'd0, 5'd7, 16'd0})
      $display("FAIL flush_bubble: got rs1=%0d rs2=%0d rd=%0d cnt=%0d want 0 0 7 0",
               bus.id_ex_rs1, bus.id_ex_rs2, bus.ex_mem_rd, stall_cycles);
    else n_pass++;
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    set_id(1, 9, 4, 0, 1, 0, 1, 1);
    tick();
    set_id(1, 10, 1, 2, 1, 1, 1, 0);
    tick();
    set_id(1, 11, 3, 4, 1, 1, 1, 0);
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      model_eval();
      n_total++;
      if ({stall_id, bubble_ex, mem_wait, bus.ex_mem_rd, bus.id_ex_rs1, bus.mem_wb_rd} !==
          {1'b1, 1'b0, (i != 0), 5'd9, 5'd1, 5'd0})
        $display("FAIL memwait_hold%0d: got stall=%b bub=%b wait=%b rd=%0d rs1=%0d wbrd=%0d",
                 i, stall_id, bubble_ex, mem_wait, bus.ex_mem_rd, bus.id_ex_rs1, bus.mem_wb_rd);
      else n_pass++;
      tick();
    end
    mem_ready = 1;
    @(negedge clk);
    model_eval();
    n_total++;
    if ({stall_id, mem_wait, stall_cycles} !== {1'b0, 1'b1, 16'd3})
      $display("FAIL memwait_release: got stall=%b wait=%b cnt=%0d want 0 1 3",
               stall_id, mem_wait, stall_cycles);
    else n_pass++;
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    model_eval();
    n_total++;
    if ({mem_wait, bus.mem_wb_rd, bus.mem_wb_reg_write, bus.ex_mem_rd, bus.id_ex_rs1} !==
        {1'b0, 5'd9, 1'b1, 5'd10, 5'd3})
      $display("FAIL memwait_advance: got wait=%b wbrd=%0d wbrw=%b rd=%0d rs1=%0d want 0 9 1 10 3",
               mem_wait, bus.mem_wb_rd, bus.mem_wb_reg_write, bus.ex_mem_rd, bus.id_ex_rs1);
    else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    set_id(1, 12, 1, 0, 1, 0, 1, 1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    mem_ready = 0;
    for (int i = 0; i <= MAX_WAIT; i++) begin
      @(negedge clk);
      model_eval();
      n_total++;
      if (mem_timeout !== 1'b0) $display("FAIL timeout_early%0d: got %b want 0", i, mem_timeout);
      else n_pass++;
      tick();
    end
    mem_ready = 1;
    @(negedge clk);
    model_eval();
    n_total++;
    if ({mem_timeout, mem_wait, stall_id, stall_cycles} !== {1'b1, 1'b1, 1'b0, 16'(MAX_WAIT + 1)})
      $display("FAIL timeout_set: got to=%b wait=%b stall=%b cnt=%0d want 1 1 0 %0d",
               mem_timeout, mem_wait, stall_id, stall_cycles, MAX_WAIT + 1);
    else n_pass++;
    tick();
    @(negedge clk);
    model_eval();
    n_total++;
    if ({mem_timeout, mem_wait} !== 2'b10)
      $display("FAIL timeout_sticky: got to=%b wait=%b want 1 0", mem_timeout, mem_wait);
    else n_pass++;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    set_id(1, 13, 2, 0, 1, 0, 1, 1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    mem_ready = 0;
    tick();
    tick();
    @(negedge clk);
    model_eval();
    n_total++;
    if ({mem_wait, stall_id} !== 2'b11) $display("FAIL areset_pre: got %b want 11", {mem_wait, stall_id});
    else n_pass++;
    @(posedge clk);
    #3;
    rst_n = 0;
    model_reset();
    #1;
    n_total++;
    if (dut_vec() !== 44'd0) $display("FAIL areset_async: got %h want 0", dut_vec());
    else n_pass++;
    mem_ready = 1;
    set_id(1, 0, 1, 2, 1, 0, 1, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    model_eval();
    n_total++;
    if ({bus.ex_mem_rd, bus.ex_mem_reg_write, mem_wait, mem_timeout} !== {5'd0, 1'b0, 1'b0, 1'b0})
      $display("FAIL areset_x0: got rd=%0d rw=%b wait=%b to=%b want 0 0 0 0",
               bus.ex_mem_rd, bus.ex_mem_reg_write, mem_wait, mem_timeout);
    else n_pass++;
    n_total++;
    if (dut_vec() !== model_vec()) $display("FAIL areset_model: got %h want %h", dut_vec(), model_vec());
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
      ex_flush  = ($urandom_range(0, 7) == 0);
      mem_ready = ($urandom_range(0, 4) != 0);
      @(negedge clk);
      model_eval();
      n_total++;
      if (dut_vec() !== model_vec()) $display("FAIL random_c%0d: got %h want %h", c, dut_vec(), model_vec());
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    model_reset();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_back_to_back();
    test_load_use();
    test_flush_load_use();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
